// File: rtl/dms_pkg.sv
// dms_pkg -- shared constants and helpers for the dms_buf demultiplexing buffer.
//   DEF_WIDTH    : default data width per channel
//   DEF_CHANNELS : default number of output channels
//   ERRCNT_W     : width of the optional out-of-range word counter
//   calc_aw()    : address width needed to index a given channel count
package dms_pkg;

  localparam int DEF_WIDTH    = 1;
  localparam int DEF_CHANNELS = 7;
  localparam int ERRCNT_W     = 8;

  // Address width for n channels; a single channel still needs one bit.
  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dms_slot.sv
// dms_slot -- one-entry channel buffer (valid bit plus data register).
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, clears valid and data
//   fill      : load fill_data this edge (takes precedence over drain)
//   fill_data : word to load
//   drain     : consumer takes the word this edge
//   valid     : buffer holds a word
//   data      : buffered word (kept after a drain)
module dms_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // A simultaneous fill and drain replaces the word and keeps valid high;
  // a lone drain only clears valid so the last word stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      data  <= fill_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dms_buf.sv
// dms_buf -- routes a single input stream to CHANNELS one-entry output buffers
// selected by in_adr. Out-of-range addresses are accepted, dropped and flagged.
// Optional feature: define DMS_BUF_ERRCNT_EN to add err_cnt, a saturating
// count of accepted out-of-range words.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   in_valid  : input word present
//   in_ready  : word accepted this cycle (combinational from in_adr)
//   in_data   : input word
//   in_adr    : destination channel index
//   out_valid : per-channel buffer full
//   out_ready : per-channel consumer accepts
//   out_data  : channel k at bits [k*WIDTH +: WIDTH]
//   err_cnt   : (DMS_BUF_ERRCNT_EN only) out-of-range word count, saturating
//   err       : sticky out-of-range flag
module dms_buf
  import dms_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int AW       = calc_aw(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [AW-1:0]             in_adr,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
`ifdef DMS_BUF_ERRCNT_EN
  output logic [ERRCNT_W-1:0]       err_cnt,
`endif
  output logic                      err
);

  logic                in_range;
  logic                sel_busy;
  logic                accept;
  logic                oor_accept;
  logic [CHANNELS-1:0] fill;
  logic [CHANNELS-1:0] drain;

  // Decode by comparing against every channel index rather than indexing
  // out_valid with in_adr, so addresses beyond CHANNELS-1 never index out of
  // range; they simply match nothing and leave the input ready.
  always_comb begin
    in_range = 1'b0;
    sel_busy = 1'b0;
    fill     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (in_adr == AW'(k)) begin
        in_range = 1'b1;
        sel_busy = out_valid[k] & ~out_ready[k];
        fill[k]  = accept;
      end
    end
  end

  assign in_ready   = ~sel_busy;
  assign accept     = in_valid & in_ready;
  assign oor_accept = accept & ~in_range;
  assign drain      = out_valid & out_ready;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
    dms_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .fill      (fill[g]),
      .fill_data (in_data),
      .drain     (drain[g]),
      .valid     (out_valid[g]),
      .data      (out_data[g*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (oor_accept) begin
      err <= 1'b1;
    end
  end

`ifdef DMS_BUF_ERRCNT_EN
  logic [ERRCNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (oor_accept && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign err_cnt = cnt;
`endif

endmodule

// File: doc/dms_buf.md
DMS_BUF -- requirements
Module: dms_buf

Interface
REQ-001 Parameter WIDTH, default 1: data width per channel, at least 1.
REQ-002 Parameter CHANNELS, default 7: number of output channels, from 2 to 64.
REQ-003 Localparam AW = $clog2(CHANNELS): address width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  input word present.
REQ-007 in_ready  out  1  block accepts the word this cycle.
REQ-008 in_data  in  WIDTH  input word.
REQ-009 in_adr  in  AW  destination channel index.
REQ-010 out_valid  out  CHANNELS  per-channel buffer full.
REQ-011 out_ready  in  CHANNELS  per-channel consumer accepts.
REQ-012 out_data  out  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-013 err  out  1  sticky flag for an out-of-range address.

Function
REQ-014 Each channel SHALL hold a one-entry buffer made of a valid bit and a WIDTH-bit data register.
REQ-015 Transfer: in_valid && in_ready at an edge = input accepted; out_valid[k] && out_ready[k] at an edge = channel k drained.
REQ-016 For in_adr < CHANNELS, in_ready SHALL be combinational: !out_valid[in_adr] || out_ready[in_adr].
REQ-017 For in_adr >= CHANNELS, in_ready SHALL be 1.
  - The accepted word is dropped.
  - err is set at the next edge.
  - No channel state changes.
REQ-018 Latency: a word accepted at edge N SHALL appear on out_data[in_adr] with out_valid high after edge N.
REQ-019 Fill and drain of the same channel at the same edge SHALL load the new word and keep out_valid high.
REQ-020 A drain with no fill SHALL clear out_valid[k] and leave the data register unchanged.
REQ-021 A channel SHALL be changed only by a fill or drain addressed to that channel.
  - Channels drain independently.
  - Several channels may drain at the same edge.
REQ-022 in_data and in_adr SHALL be ignored when in_valid is 0.
REQ-023 err SHALL stay set until reset.

Reset
REQ-024 While rst is high at an edge:
  - All out_valid SHALL be 0.
  - All out_data SHALL be 0.
  - err SHALL be 0.
  - Reset takes priority over any concurrent fill or drain.
REQ-025 in_ready during reset SHALL follow REQ-016/017 from the cleared state; words accepted in a reset cycle are discarded.
REQ-026 Reset mid-operation SHALL discard all buffered words; nothing is flushed.

Configuration
REQ-027 Macro DMS_BUF_ERRCNT_EN, when defined, SHALL add output err_cnt (out, 8 bits).
  - Counts accepted out-of-range words.
  - Saturates at 255.
  - Cleared by rst.
REQ-028 Without DMS_BUF_ERRCNT_EN, err_cnt and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package dms_pkg SHALL hold:
  - default WIDTH and CHANNELS constants;
  - ERRCNT_W = 8;
  - a function computing AW.
REQ-030 Sub-module dms_slot SHALL implement one channel buffer.
  - Ports: clk, rst, fill, fill_data, drain, valid, data.
  - dms_buf instantiates it CHANNELS times in a generate loop.

Verification
REQ-031 Basic routing (defaults), in_adr=3, in_data=1, in_valid=1 for one cycle, out_ready=0 -> out_valid=7'b0001000 and out_data[3]=1 from the next cycle; in_ready=0 for further words to adr 3.
REQ-032 Backpressure: channel 2 full, out_ready[2]=0, new word to adr 2 -> in_ready=0 and the word is held; raise out_ready[2] -> drain and fill in the same cycle, out_valid[2] stays 1, new data visible next cycle.
REQ-033 Out-of-range (defaults), in_adr=7, in_valid=1 -> in_ready=1, err=1 next cycle, out_valid unchanged; with the macro defined, err_cnt=1; after 300 such words err_cnt=255.
REQ-034 Parallel drain: WIDTH=8, CHANNELS=4, fill channels 0..3 with 8'hA0..8'hA3, then out_ready=4'hF for one cycle -> all out_valid=0 next cycle, out_data unchanged.
REQ-035 Reset mid-operation: channels 1 and 5 full, err=1, rst=1 for one cycle with a concurrent fill -> all out_valid=0, out_data=0, err=0.
